// File: rtl/ctrl_decode_exmem_pkg.sv
// Shared definitions for the ID-stage control decode and the EX/MEM control slice.
// Opcodes, instruction-class codes for bits [27:25], and the control bundle layout.
package ctrl_decode_exmem_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_RSB = 4'b0011;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_RSC = 4'b0111;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_TEQ = 4'b1001;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_CMN = 4'b1011;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_BIC = 4'b1110;
  localparam logic [3:0] OP_MVN = 4'b1111;

  localparam logic [2:0] CLS_DP_REG = 3'b000;
  localparam logic [2:0] CLS_DP_IMM = 3'b001;
  localparam logic [2:0] CLS_LS_IMM = 3'b010;
  localparam logic [2:0] CLS_LS_REG = 3'b011;
  localparam logic [2:0] CLS_BRANCH = 3'b101;

  typedef struct packed {
    logic [3:0] opcode;
    logic       am;
    logic       s_en;
    logic       load;
    logic       rf;
    logic       size;
    logic       rw;
    logic       en;
    logic       bl;
    logic       b;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

  // Flag-only ops produce no register result.
  function automatic logic is_compare_op(input logic [3:0] op);
    return (op >= OP_TST) && (op <= OP_CMN);
  endfunction

endpackage

// File: rtl/ctrl_decode_exmem_decoder.sv
// Pure combinational decode of an ID-stage instruction into the control bundle.
// The condition field is not examined here.
module ctrl_decoder
  import ctrl_decode_exmem_pkg::*;
(
  input  logic [31:0] i_instr,
  output ctrl_t       o_ctrl
);

  logic [2:0] w_class;

  assign w_class = i_instr[27:25];

  always_comb begin
    o_ctrl = CTRL_NONE;
    if (i_instr != 32'h0) begin
      case (w_class)
        CLS_DP_REG, CLS_DP_IMM: begin
          o_ctrl.opcode = i_instr[24:21];
          o_ctrl.s_en   = i_instr[20];
          o_ctrl.am     = i_instr[25];
          o_ctrl.rf     = ~is_compare_op(i_instr[24:21]);
        end
        CLS_LS_IMM, CLS_LS_REG: begin
          // I=0 encodes an immediate offset, hence the inverted AM
          o_ctrl.en     = 1'b1;
          o_ctrl.load   = i_instr[20];
          o_ctrl.rf     = i_instr[20];
          o_ctrl.rw     = ~i_instr[20];
          o_ctrl.size   = i_instr[22];
          o_ctrl.am     = ~i_instr[25];
          o_ctrl.opcode = i_instr[23] ? OP_ADD : OP_SUB;
        end
        CLS_BRANCH: begin
          o_ctrl.b      = 1'b1;
          o_ctrl.bl     = i_instr[24];
          o_ctrl.rf     = i_instr[24];
          o_ctrl.opcode = OP_AND;
        end
        default: o_ctrl = CTRL_NONE;
      endcase
    end
  end

endmodule

// File: rtl/ctrl_decode_exmem.sv
// ID-stage control decode with bubble mux, plus the EX/MEM memory/writeback control register.
// Only the EX/MEM slice holds state; the ID outputs follow the instruction combinationally.
module ctrl_decode_exmem
  import ctrl_decode_exmem_pkg::*;
(
  input  logic        clk,
  input  logic        R,
  input  logic [31:0] in_instruction,
  input  logic        S,
  output logic [3:0]  ID_opcode,
  output logic        ID_AM,
  output logic        ID_S_enable,
  output logic        ID_load_instr,
  output logic        ID_RF_enable,
  output logic        ID_Size_enable,
  output logic        ID_RW_enable,
  output logic        ID_Enable_signal,
  output logic        ID_BL_instr,
  output logic        ID_B_instr,
  input  logic        in_EX_load_instr,
  input  logic        in_EX_RF_enable,
  input  logic        in_EX_Size_enable,
  input  logic        in_EX_RW_enable,
  input  logic        in_EX_Enable_signal,
  output logic        MEM_load_instr,
  output logic        MEM_RF_enable,
  output logic        MEM_Size_enable,
  output logic        MEM_RW_enable,
  output logic        MEM_Enable_signal
);

  ctrl_t      w_dec;
  ctrl_t      w_id;
  logic [4:0] w_ex;
  logic [4:0] r_mem;

  ctrl_decoder u_decoder (
    .i_instr (in_instruction),
    .o_ctrl  (w_dec)
  );

  // Bubble insertion zeroes the whole bundle in the same cycle
  assign w_id = S ? CTRL_NONE : w_dec;

  assign ID_opcode        = w_id.opcode;
  assign ID_AM            = w_id.am;
  assign ID_S_enable      = w_id.s_en;
  assign ID_load_instr    = w_id.load;
  assign ID_RF_enable     = w_id.rf;
  assign ID_Size_enable   = w_id.size;
  assign ID_RW_enable     = w_id.rw;
  assign ID_Enable_signal = w_id.en;
  assign ID_BL_instr      = w_id.bl;
  assign ID_B_instr       = w_id.b;

  assign w_ex = {in_EX_load_instr, in_EX_RF_enable, in_EX_Size_enable,
                 in_EX_RW_enable, in_EX_Enable_signal};

  always_ff @(posedge clk) begin
    if (R) r_mem <= 5'b0;
    else   r_mem <= w_ex;
  end

  assign MEM_load_instr    = r_mem[4];
  assign MEM_RF_enable     = r_mem[3];
  assign MEM_Size_enable   = r_mem[2];
  assign MEM_RW_enable     = r_mem[1];
  assign MEM_Enable_signal = r_mem[0];

endmodule

// File: tb/tb_ctrl_decode_exmem.sv
// Scoreboard bench for ctrl_decode_exmem: directed instructions then randomized traffic,
// checked against an instruction-level reference model.
module tb_ctrl_decode_exmem;

  logic        clk = 1'b0;
  logic        R = 1'b1;
  logic [31:0] in_instruction = 32'h0;
  logic        S = 1'b0;
  logic [3:0]  ID_opcode;
  logic        ID_AM, ID_S_enable, ID_load_instr, ID_RF_enable, ID_Size_enable;
  logic        ID_RW_enable, ID_Enable_signal, ID_BL_instr, ID_B_instr;
  logic        ex_load = 1'b0, ex_rf = 1'b0, ex_size = 1'b0, ex_rw = 1'b0, ex_en = 1'b0;
  logic        MEM_load_instr, MEM_RF_enable, MEM_Size_enable, MEM_RW_enable, MEM_Enable_signal;

  int tests  = 0;
  int failed = 0;

  typedef struct {
    logic [12:0] id_exp;
    logic [4:0]  mem_exp;
    logic [31:0] instr;
    logic        s;
  } txn_t;

  txn_t sb_q[$];

  always #5 clk = ~clk;

  ctrl_decode_exmem dut (
    .clk(clk), .R(R), .in_instruction(in_instruction), .S(S),
    .ID_opcode(ID_opcode), .ID_AM(ID_AM), .ID_S_enable(ID_S_enable),
    .ID_load_instr(ID_load_instr), .ID_RF_enable(ID_RF_enable),
    .ID_Size_enable(ID_Size_enable), .ID_RW_enable(ID_RW_enable),
    .ID_Enable_signal(ID_Enable_signal), .ID_BL_instr(ID_BL_instr), .ID_B_instr(ID_B_instr),
    .in_EX_load_instr(ex_load), .in_EX_RF_enable(ex_rf), .in_EX_Size_enable(ex_size),
    .in_EX_RW_enable(ex_rw), .in_EX_Enable_signal(ex_en),
    .MEM_load_instr(MEM_load_instr), .MEM_RF_enable(MEM_RF_enable),
    .MEM_Size_enable(MEM_Size_enable), .MEM_RW_enable(MEM_RW_enable),
    .MEM_Enable_signal(MEM_Enable_signal)
  );

  // Reference: {opcode, AM, S, load, RF, Size, RW, Enable, BL, B}
  function automatic logic [12:0] ref_id(input logic [31:0] ins, input logic bubble);
    int cls, op;
    logic [3:0] opc;
    logic am, s_en, ld, rf, sz, rw, en, bl, b;
    opc = 4'd0; am = 0; s_en = 0; ld = 0; rf = 0; sz = 0; rw = 0; en = 0; bl = 0; b = 0;
    cls = int'(ins[27:25]);
    if (!bubble && ins != 32'h0) begin
      if (cls == 0 || cls == 1) begin
        op   = int'(ins[24:21]);
        opc  = ins[24:21];
        s_en = ins[20];
        am   = (cls == 1);
        rf   = !(op >= 8 && op <= 11);
      end else if (cls == 2 || cls == 3) begin
        en  = 1;
        ld  = ins[20];
        rf  = ins[20];
        rw  = !ins[20];
        sz  = ins[22];
        am  = (cls == 2);
        opc = ins[23] ? 4'd4 : 4'd2;
      end else if (cls == 5) begin
        b  = 1;
        bl = ins[24];
        rf = ins[24];
      end
    end
    return {opc, am, s_en, ld, rf, sz, rw, en, bl, b};
  endfunction

  task automatic issue(input logic [31:0] ins, input logic s, input logic r, input logic [4:0] ex);
    txn_t t;
    @(negedge clk);
    in_instruction = ins;
    S = s;
    R = r;
    {ex_load, ex_rf, ex_size, ex_rw, ex_en} = ex;
    #1;
    t.id_exp  = ref_id(ins, s);
    t.mem_exp = r ? 5'b0 : ex;
    t.instr   = ins;
    t.s       = s;
    sb_q.push_back(t);
  endtask

  // Monitor: ID checked just after the edge (inputs stable since the prior negedge),
  // MEM checked against what that edge should have captured.
  initial begin
    txn_t t;
    logic [12:0] id_got;
    logic [4:0]  mem_got;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        t = sb_q.pop_front();
        id_got = {ID_opcode, ID_AM, ID_S_enable, ID_load_instr, ID_RF_enable,
                  ID_Size_enable, ID_RW_enable, ID_Enable_signal, ID_BL_instr, ID_B_instr};
        mem_got = {MEM_load_instr, MEM_RF_enable, MEM_Size_enable, MEM_RW_enable,
                   MEM_Enable_signal};
        tests++;
        if (id_got !== t.id_exp) begin
          failed++;
          $display("FAIL id_ctrl instr=%h S=%b got=%b exp=%b", t.instr, t.s, id_got, t.id_exp);
        end
        tests++;
        if (mem_got !== t.mem_exp) begin
          failed++;
          $display("FAIL mem_ctrl got=%b exp=%b", mem_got, t.mem_exp);
        end
      end
    end
  end

  initial begin
    logic [31:0] ins;
    logic [2:0]  cls_pick [6];
    int          k;
    cls_pick[0] = 3'b000; cls_pick[1] = 3'b001; cls_pick[2] = 3'b010;
    cls_pick[3] = 3'b011; cls_pick[4] = 3'b101; cls_pick[5] = 3'b100;

    // Reset must win over all-ones EX data
    issue(32'h0,        1'b0, 1'b1, 5'b11111);
    issue(32'hE0921003, 1'b0, 1'b0, 5'b10101);
    issue(32'hE3510000, 1'b0, 1'b0, 5'b01010);
    issue(32'hE5921004, 1'b0, 1'b0, 5'b11111);
    issue(32'hE5421001, 1'b0, 1'b1, 5'b11111);
    issue(32'hEB000004, 1'b0, 1'b0, 5'b00000);
    issue(32'hEB000004, 1'b1, 1'b0, 5'b10101);
    issue(32'hE5921004, 1'b1, 1'b0, 5'b01110);
    issue(32'hEA000004, 1'b0, 1'b0, 5'b10001);

    for (int i = 0; i < 400; i++) begin
      ins = $urandom;
      k = $urandom_range(0, 6);
      if (k < 6) ins[27:25] = cls_pick[k];
      if ($urandom_range(0, 19) == 0) ins = 32'h0;
      issue(ins, ($urandom_range(0, 4) == 0), ($urandom_range(0, 15) == 0),
            5'($urandom_range(0, 31)));
    end

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
    #2;
    if (sb_q.size() > 0) begin
      tests++;
      failed++;
      $display("FAIL drain pending=%0d required=0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
